instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: mem_req  output  1  instruction-memory read request.
REQ-004 SHALL have port: mem_addr  output  10  word address (= PC while mem_req high).
REQ-005 SHALL have port: mem_ack  input  1  read completes this cycle; mem_rdata valid.
REQ-006 SHALL have port: mem_rdata  input  16  instruction word.
REQ-007 SHALL have port: opcode  output  6  IR[15:10], drives control unit opcode input.
REQ-008 SHALL have port: reg_sel  output  1  IR[9].
REQ-009 SHALL have port: imm  output  9  IR[8:0].
REQ-010 SHALL have port: ir_valid  output  1  opcode/reg_sel/imm hold a valid instruction.
REQ-011 SHALL have port: ir_ready  input  1  control unit consumes instruction this cycle.
REQ-012 SHALL have port: br_taken  input  1  single-cycle redirect pulse from control unit (BRA path).
REQ-013 SHALL have port: br_target  input  10  redirect address, sampled when br_taken high.
REQ-014 SHALL have parameter: HALT_OP, default 6'b111111, opcode that stops fetching.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD, STOP.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 REQ SHALL assert mem_req with mem_addr = PC and hold both stable until mem_ack.
REQ-018 On mem_ack in REQ (no redirect pending) SHALL capture mem_rdata into IR, PC <= PC+1, go HOLD.
REQ-019 HOLD SHALL assert ir_valid; IR and outputs stable until ir_ready.
REQ-020 On ir_ready in HOLD SHALL go REQ, or STOP if opcode == HALT_OP.
REQ-021 Throughput SHALL be one instruction per 2 cycles with zero-wait memory (ack in first REQ cycle).
REQ-022 PC SHALL be 10-bit, wrapping 10'h3FF -> 10'h000 with no flag.
REQ-023 br_taken in HOLD or STOP SHALL set PC <= br_target, drop ir_valid next cycle, go REQ.
REQ-024 br_taken in REQ without mem_ack SHALL latch br_target as pending redirect; mem_addr unchanged until ack.
REQ-025 mem_ack with redirect pending (or br_taken same cycle) SHALL discard mem_rdata, PC <= target, clear pending, stay REQ.
REQ-026 br_taken and ir_ready in same HOLD cycle: branch wins, PC <= br_target, HALT check ignored.
REQ-027 STOP SHALL keep mem_req=0, ir_valid=0 until br_taken or rst.
REQ-028 br_taken in IDLE SHALL set PC <= br_target; next state still REQ.
REQ-029 mem_ack outside REQ SHALL be ignored.

Reset
REQ-030 rst high SHALL asynchronously force: state IDLE, PC=0, IR=0, pending=0, mem_req=0, ir_valid=0, opcode/reg_sel/imm=0.
REQ-031 Reset mid-transaction SHALL abandon the read; no IR update from an ack during or after reset until next REQ.

Structure
REQ-032 SHALL place ADDR_W=10, INSTR_W=16, OPC_W=6, HALT_OP and the FSM state enum in shared package gpp_pkg.
REQ-033 SHALL instantiate one sub-module pc_counter (load/increment/wrap, async reset).

Verification
REQ-034 Reset, mem acks first REQ cycle, rdata 16'h0C05, ir_ready on first ir_valid -> mem_addr 0,1,2..., opcode 6'h03, imm 9'h005, ir_valid every other cycle.
REQ-035 ack delayed 3 cycles -> mem_req/mem_addr 10'h000 stable 4 cycles, single IR load.
REQ-036 br_taken target 10'h120 during REQ before delayed ack -> first ack data discarded, next mem_addr 10'h120.
REQ-037 ir_ready and br_taken same cycle, target 10'h3FF -> next fetch 10'h3FF, then 10'h000 (wrap).
REQ-038 IR opcode 6'b111111 consumed -> STOP, mem_req low 10 cycles; br_taken target 10'h010 -> fetch resumes at 10'h010.
REQ-039 rst pulsed while in HOLD -> all outputs 0 immediately, fetch restarts at 10'h000 after IDLE.

Source files
------------

// File: rtl/gpp_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   ADDR_W / INSTR_W / OPC_W : address, instruction word and opcode widths
//   HALT_OP                  : default opcode that stops fetching
//   fetch_state_e            : fetch FSM states
//   ir_opcode()              : opcode field extraction from an instruction word
package gpp_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 6;
  localparam int IMM_W   = 9;

  localparam logic [OPC_W-1:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [INSTR_W-1:0] ir);
    return ir[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's memory-side and control-unit-side signals.
//   mem_req/mem_addr  -> instruction memory read request and word address
//   mem_ack/mem_rdata <- read completion and instruction word
//   opcode/reg_sel/imm/ir_valid -> decoded instruction register to control unit
//   ir_ready          <- control unit consumes the instruction
//   br_taken/br_target <- single-cycle redirect from control unit
// master: the fetch unit. slave: memory + control unit (or a testbench).
interface instr_fetch_if;
  import gpp_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [OPC_W-1:0]   opcode;
  logic               reg_sel;
  logic [IMM_W-1:0]   imm;
  logic               ir_valid;
  logic               ir_ready;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;

  modport master (
    output mem_req, mem_addr, opcode, reg_sel, imm, ir_valid,
    input  mem_ack, mem_rdata, ir_ready, br_taken, br_target
  );

  modport slave (
    input  mem_req, mem_addr, opcode, reg_sel, imm, ir_valid,
    output mem_ack, mem_rdata, ir_ready, br_taken, br_target
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: loadable, incrementing, wraps silently at the top of the
// address space.
//   clk, rst     : clock, asynchronous active-high reset (PC -> 0)
//   load_i       : load load_val_i this cycle (takes priority over inc_i)
//   load_val_i   : value to load
//   inc_i        : advance PC by one
//   pc_o         : current PC
module pc_counter
  import gpp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);  // natural 10-bit wrap 3FF -> 000
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one instruction word per request from the
// instruction memory, holds it in the IR until the control unit takes it, and
// follows single-cycle branch redirects from the control unit.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_fetch_if.master (memory request/response, decoded IR,
//              ir_ready handshake, br_taken/br_target redirect)
//   HALT_OP  : opcode that parks the unit in STOP once consumed
module instr_fetch
  import gpp_pkg::*;
#(
  parameter logic [OPC_W-1:0] HALT_OP = gpp_pkg::HALT_OP
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        bus
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               pend_q;       // redirect arrived while a read was outstanding
  logic [ADDR_W-1:0]  pend_tgt_q;
  logic               mem_req_q;
  logic               ir_valid_q;

  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;

  pc_counter u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // PC control. The outstanding read keeps using the old PC until it is
  // acknowledged; only then is a pending (or same-cycle) redirect applied.
  // A live br_taken beats an older pending target.
  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = bus.br_target;
    pc_inc      = 1'b0;
    unique case (state_q)
      IDLE, HOLD, STOP: pc_load = bus.br_taken;
      REQ: begin
        if (bus.mem_ack) begin
          if (bus.br_taken) begin
            pc_load = 1'b1;
          end else if (pend_q) begin
            pc_load     = 1'b1;
            pc_load_val = pend_tgt_q;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q   <= REQ;
          mem_req_q <= 1'b1;
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (bus.br_taken || pend_q) begin
              // Data belongs to the abandoned path: drop it, refetch at target.
              pend_q <= 1'b0;
            end else begin
              ir_q       <= bus.mem_rdata;
              state_q    <= HOLD;
              mem_req_q  <= 1'b0;
              ir_valid_q <= 1'b1;
            end
          end else if (bus.br_taken) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= bus.br_target;
          end
        end
        HOLD: begin
          if (bus.br_taken) begin
            // Branch wins over consumption; the HALT check is skipped.
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            ir_valid_q <= 1'b0;
          end else if (bus.ir_ready) begin
            ir_valid_q <= 1'b0;
            if (ir_opcode(ir_q) == HALT_OP) begin
              state_q <= STOP;
            end else begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        STOP: begin
          if (bus.br_taken) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          mem_req_q  <= 1'b0;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc;
  assign bus.ir_valid = ir_valid_q;
  assign bus.opcode   = ir_opcode(ir_q);
  assign bus.reg_sel  = ir_q[IMM_W];
  assign bus.imm      = ir_q[IMM_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a transaction-level reference model
// and a per-cycle compare process, plus literal checks for the key scenarios.
module tb_instr_fetch;
  import gpp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(.HALT_OP(6'b111111)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory responder ----------------
  logic [15:0] imem [1024];
  int          ack_delay = 0;
  bit          force_ack = 0;

  initial begin
    int cnt;
    cnt           = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hABCD;
      end else if (bus.mem_req === 1'b1) begin
        if (cnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = imem[bus.mem_addr];
          cnt           = 0;
        end else begin
          bus.mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        cnt         = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks which phase of a fetch the unit is in and the architectural PC/IR.
  logic        m_idle, m_fetch, m_hold, m_stop, m_redir;
  logic [9:0]  m_pc, m_redir_pc;
  logic [15:0] m_ir;

  function automatic logic [9:0] next_pc(input logic [9:0] pc);
    int v;
    v = int'(pc) + 1;
    if (v == 1024) v = 0;
    return 10'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1; m_fetch <= 1'b0; m_hold <= 1'b0; m_stop <= 1'b0;
      m_redir <= 1'b0; m_redir_pc <= '0; m_pc <= '0; m_ir <= '0;
    end else if (m_idle) begin
      m_idle  <= 1'b0;
      m_fetch <= 1'b1;
      if (bus.br_taken) m_pc <= bus.br_target;
    end else if (m_fetch) begin
      if (bus.mem_ack) begin
        if (bus.br_taken) begin
          m_pc <= bus.br_target; m_redir <= 1'b0;
        end else if (m_redir) begin
          m_pc <= m_redir_pc; m_redir <= 1'b0;
        end else begin
          m_ir <= bus.mem_rdata; m_pc <= next_pc(m_pc);
          m_fetch <= 1'b0; m_hold <= 1'b1;
        end
      end else if (bus.br_taken) begin
        m_redir <= 1'b1; m_redir_pc <= bus.br_target;
      end
    end else if (m_hold) begin
      if (bus.br_taken) begin
        m_pc <= bus.br_target; m_hold <= 1'b0; m_fetch <= 1'b1;
      end else if (bus.ir_ready) begin
        m_hold <= 1'b0;
        if (m_ir[15:10] == 6'b111111) m_stop <= 1'b1;
        else                          m_fetch <= 1'b1;
      end
    end else if (m_stop && bus.br_taken) begin
      m_pc <= bus.br_target; m_stop <= 1'b0; m_fetch <= 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("mem_req", 32'(bus.mem_req), 32'(m_fetch));
    if (m_fetch) check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
    check("ir_valid", 32'(bus.ir_valid), 32'(m_hold));
    check("ir_fields", 32'({bus.opcode, bus.reg_sel, bus.imm}), 32'(m_ir));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (bus.ir_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.ir_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    bus.ir_ready  = 1'b1;
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0C05;

    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    rst = 1'b0;

    // Zero-wait stream: one instruction every two cycles, sequential addresses.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_req", 32'(bus.mem_req), 32'd1);
      check("t1_addr", 32'(bus.mem_addr), 32'(k));
      @(negedge clk);
      check("t1_valid", 32'(bus.ir_valid), 32'd1);
      check("t1_opcode", 32'(bus.opcode), 32'h03);
      check("t1_imm", 32'(bus.imm), 32'h005);
    end

    // Ack delayed three cycles: request held four cycles at address 0.
    imem[0]      = 16'h1234;
    imem[1]      = 16'h5555;
    imem[10'h120] = 16'h0A01;
    imem[10'h050] = 16'hFC07;
    ack_delay    = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_req", 32'(bus.mem_req), 32'd1);
      check("t2_addr", 32'(bus.mem_addr), 32'h000);
    end
    @(negedge clk);
    check("t2_valid", 32'(bus.ir_valid), 32'd1);
    check("t2_opcode", 32'(bus.opcode), 32'h04);
    check("t2_reg_sel", 32'(bus.reg_sel), 32'd1);
    check("t2_imm", 32'(bus.imm), 32'h034);

    // Redirect to 0x120 while the read of address 1 is outstanding.
    @(negedge clk);
    check("t3_addr_before", 32'(bus.mem_addr), 32'h001);
    bus.br_taken  = 1'b1;
    bus.br_target = 10'h120;
    @(negedge clk);
    bus.br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t3_addr_held", 32'(bus.mem_addr), 32'h001);
      @(negedge clk);
    end
    check("t3_addr_held", 32'(bus.mem_addr), 32'h001);
    @(negedge clk);
    check("t3_req", 32'(bus.mem_req), 32'd1);
    check("t3_addr_target", 32'(bus.mem_addr), 32'h120);
    check("t3_no_valid", 32'(bus.ir_valid), 32'd0);
    wait_valid("t3_valid", 10);
    check("t3_opcode", 32'(bus.opcode), 32'h02);
    check("t3_imm", 32'(bus.imm), 32'h001);

    // Consume and branch in the same cycle, target at the top of memory.
    ack_delay     = 0;
    bus.br_taken  = 1'b1;
    bus.br_target = 10'h3FF;
    @(negedge clk);
    bus.br_taken = 1'b0;
    check("t4_req", 32'(bus.mem_req), 32'd1);
    check("t4_addr_top", 32'(bus.mem_addr), 32'h3FF);
    @(negedge clk);
    check("t4_valid", 32'(bus.ir_valid), 32'd1);
    @(negedge clk);
    check("t4_addr_wrap", 32'(bus.mem_addr), 32'h000);

    // Branch to a HALT instruction, then sit in STOP, then resume at 0x010.
    wait_valid("t5_pre_valid", 10);
    bus.br_taken  = 1'b1;
    bus.br_target = 10'h050;
    @(negedge clk);
    bus.br_taken = 1'b0;
    check("t5_addr_halt", 32'(bus.mem_addr), 32'h050);
    wait_valid("t5_halt_valid", 10);
    check("t5_halt_opcode", 32'(bus.opcode), 32'h3F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      force_ack = (i == 4);  // stray ack while stopped must be ignored
      check("t5_stop_req", 32'(bus.mem_req), 32'd0);
      check("t5_stop_valid", 32'(bus.ir_valid), 32'd0);
    end
    check("t5_stop_opcode", 32'(bus.opcode), 32'h3F);
    bus.br_taken  = 1'b1;
    bus.br_target = 10'h010;
    @(negedge clk);
    bus.br_taken = 1'b0;
    check("t5_resume_req", 32'(bus.mem_req), 32'd1);
    check("t5_resume_addr", 32'(bus.mem_addr), 32'h010);

    // Asynchronous reset while holding an instruction.
    wait_valid("t6_valid", 10);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req", 32'(bus.mem_req), 32'd0);
    check("t6_rst_valid", 32'(bus.ir_valid), 32'd0);
    check("t6_rst_fields", 32'({bus.opcode, bus.reg_sel, bus.imm}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_restart_req", 32'(bus.mem_req), 32'd1);
    check("t6_restart_addr", 32'(bus.mem_addr), 32'h000);
    wait_valid("t6_restart_valid", 10);

    // Branch during the IDLE cycle right after reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_target = 10'h0AA;
    @(negedge clk);
    bus.br_taken = 1'b0;
    check("t7_idle_br_addr", 32'(bus.mem_addr), 32'h0AA);
    wait_valid("t7_valid", 10);

    // Control unit stalls, then redirects out of HOLD.
    bus.ir_ready = 1'b0;
    @(negedge clk);
    check("t8_hold_valid", 32'(bus.ir_valid), 32'd1);
    bus.br_taken  = 1'b1;
    bus.br_target = 10'h200;
    @(negedge clk);
    bus.br_taken = 1'b0;
    bus.ir_ready = 1'b1;
    check("t8_drop_valid", 32'(bus.ir_valid), 32'd0);
    check("t8_addr", 32'(bus.mem_addr), 32'h200);
    wait_valid("t8_valid", 10);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
